// File: rtl/trap_sequencer.sv
// Trap response sequencer: edge-detects trap causes, drives flush/redirect toward the
// handler, tracks handler execution and mret return, and holds the trap CSRs.
module trap_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  trap_type,
  input  logic [31:0] mepc_in,
  input  logic [31:0] mtvec_addr,
  input  logic        mret,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler,
  output logic        halted
);

  localparam int unsigned FC_W = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLUSH    = 3'd1;
  localparam logic [2:0] S_REDIRECT = 3'd2;
  localparam logic [2:0] S_HANDLER  = 3'd3;
  localparam logic [2:0] S_RETURN   = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;

  localparam logic [FC_W-1:0] FCNT_INIT = FC_W'(FLUSH_CYCLES - 1);

  logic [2:0]       state_q, state_n;
  logic [2:0]       trap_type_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_n;
  logic [31:0]      mepc_q, mepc_n;
  logic [2:0]       mcause_q, mcause_n;
  logic [31:0]      mtvec_q, mtvec_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             trap_edge;

  logic        flush_n, pc_redirect_n, in_handler_n, halted_n;
  logic [31:0] redirect_pc_n;

  assign trap_edge = (trap_type != 3'd0) && (trap_type_d == 3'd0);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State register and all architectural/output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      trap_type_d <= 3'd0;
      fcnt_q      <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtvec_q     <= '0;
      cnt_q       <= '0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      in_handler  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_n;
      trap_type_d <= trap_type;
      fcnt_q      <= fcnt_n;
      mepc_q      <= mepc_n;
      mcause_q    <= mcause_n;
      mtvec_q     <= mtvec_n;
      cnt_q       <= cnt_n;
      flush       <= flush_n;
      pc_redirect <= pc_redirect_n;
      redirect_pc <= redirect_pc_n;
      in_handler  <= in_handler_n;
      halted      <= halted_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register as Moore outputs
  always_comb begin
    state_n       = state_q;
    fcnt_n        = fcnt_q;
    mepc_n        = mepc_q;
    mcause_n      = mcause_q;
    mtvec_n       = mtvec_q;
    cnt_n         = cnt_q;
    flush_n       = 1'b0;
    pc_redirect_n = 1'b0;
    redirect_pc_n = '0;
    in_handler_n  = 1'b0;
    halted_n      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trap_edge) begin
          mcause_n = trap_type;
          mtvec_n  = mtvec_addr;
          fcnt_n   = FCNT_INIT;
          cnt_n    = cnt_inc;
          state_n  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // mepc_in becomes valid one cycle after the trap edge, i.e. in the first FLUSH cycle
        if (fcnt_q == FCNT_INIT) mepc_n = mepc_in;
        if (fcnt_q != '0) fcnt_n = fcnt_q - FC_W'(1);
        else              state_n = S_REDIRECT;
      end
      S_REDIRECT: state_n = S_HANDLER;
      S_HANDLER: begin
        if (trap_edge) begin
          cnt_n   = cnt_inc;
          state_n = S_HALT;
        end else if (mret) begin
          state_n = S_RETURN;
        end
      end
      S_RETURN: state_n = S_IDLE;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase

    case (state_n)
      S_FLUSH: flush_n = 1'b1;
      S_REDIRECT: begin
        flush_n       = 1'b1;
        pc_redirect_n = 1'b1;
        redirect_pc_n = mtvec_n;
      end
      S_HANDLER: in_handler_n = 1'b1;
      S_RETURN: begin
        flush_n       = 1'b1;
        pc_redirect_n = 1'b1;
        redirect_pc_n = mepc_n;
        in_handler_n  = 1'b1;
      end
      S_HALT: begin
        flush_n  = 1'b1;
        halted_n = 1'b1;
      end
      default: ;
    endcase
  end

  // Combinational CSR read port
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = {29'b0, mcause_q};
      12'h305: csr_rdata = mtvec_q;
      12'h7C0: csr_rdata = 32'(cnt_q);
      default: csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a per-cycle vector table for the main trap/return/
// double-fault flow, then hand sequences for async reset, held levels and counter saturation.
module tb_trap_sequencer;

  logic        clk;
  logic        rstn;
  logic [2:0]  trap_type;
  logic [31:0] mepc_in;
  logic [31:0] mtvec_addr;
  logic        mret;
  logic [11:0] csr_raddr;

  logic [31:0] csr_rdata, redirect_pc;
  logic        flush, pc_redirect, in_handler, halted;
  logic [31:0] csr_rdata2, redirect_pc2;
  logic        flush2, pc_redirect2, in_handler2, halted2;

  int n_checks = 0;
  int n_pass   = 0;

  trap_sequencer dut (
    .clk(clk), .rstn(rstn), .trap_type(trap_type), .mepc_in(mepc_in),
    .mtvec_addr(mtvec_addr), .mret(mret), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .in_handler(in_handler), .halted(halted)
  );

  // Narrow counter and longer flush to exercise saturation and the latency parameter
  trap_sequencer #(.FLUSH_CYCLES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .trap_type(trap_type), .mepc_in(mepc_in),
    .mtvec_addr(mtvec_addr), .mret(mret), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata2), .flush(flush2), .pc_redirect(pc_redirect2),
    .redirect_pc(redirect_pc2), .in_handler(in_handler2), .halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  tt;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic        mret;
    logic [11:0] raddr;
    logic        e_flush;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_inh;
    logic        e_halt;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic [2:0] tt, input logic mr);
    @(negedge clk);
    trap_type = tt;
    mret      = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".flush"},       32'(flush),       32'd0);
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'd0);
    chk({tag, ".redirect_pc"}, redirect_pc,      32'd0);
    chk({tag, ".in_handler"},  32'(in_handler),  32'd0);
    chk({tag, ".halted"},      32'(halted),      32'd0);
  endtask

  initial begin
    // tt, mepc_in, mtvec, mret, raddr | flush, redir, rpc, in_handler, halted, rdata
    vecs[0]  = '{3'd0, 32'h0,   32'd0,   1'b0, 12'h342, 1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 32'd0};
    vecs[1]  = '{3'd2, 32'h0,   32'd480, 1'b0, 12'h342, 1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 32'd2};
    vecs[2]  = '{3'd2, 32'h104, 32'd480, 1'b0, 12'h341, 1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 32'h104};
    vecs[3]  = '{3'd2, 32'h104, 32'd480, 1'b0, 12'h305, 1'b1, 1'b1, 32'd480,   1'b0, 1'b0, 32'd480};
    vecs[4]  = '{3'd0, 32'h104, 32'd480, 1'b0, 12'h7C0, 1'b0, 1'b0, 32'd0,     1'b1, 1'b0, 32'd1};
    vecs[5]  = '{3'd0, 32'h104, 32'd480, 1'b0, 12'h342, 1'b0, 1'b0, 32'd0,     1'b1, 1'b0, 32'd2};
    vecs[6]  = '{3'd0, 32'h104, 32'd480, 1'b1, 12'h341, 1'b1, 1'b1, 32'h104,   1'b1, 1'b0, 32'h104};
    vecs[7]  = '{3'd0, 32'h104, 32'd480, 1'b0, 12'h341, 1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 32'h104};
    vecs[8]  = '{3'd0, 32'h104, 32'd480, 1'b1, 12'h7C0, 1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 32'd1};
    vecs[9]  = '{3'd0, 32'h104, 32'd480, 1'b0, 12'h300, 1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 32'd0};
    vecs[10] = '{3'd1, 32'h208, 32'h200, 1'b0, 12'h342, 1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 32'd1};
    vecs[11] = '{3'd0, 32'h208, 32'h200, 1'b0, 12'h341, 1'b1, 1'b0, 32'd0,     1'b0, 1'b0, 32'h208};
    vecs[12] = '{3'd3, 32'h208, 32'h300, 1'b0, 12'h305, 1'b1, 1'b1, 32'h200,   1'b0, 1'b0, 32'h200};
    vecs[13] = '{3'd3, 32'h208, 32'h300, 1'b0, 12'h7C0, 1'b0, 1'b0, 32'd0,     1'b1, 1'b0, 32'd2};
    vecs[14] = '{3'd0, 32'h208, 32'h300, 1'b0, 12'h342, 1'b0, 1'b0, 32'd0,     1'b1, 1'b0, 32'd1};
    vecs[15] = '{3'd1, 32'h208, 32'h300, 1'b1, 12'h7C0, 1'b1, 1'b0, 32'd0,     1'b0, 1'b1, 32'd3};
    vecs[16] = '{3'd0, 32'h208, 32'h300, 1'b1, 12'h341, 1'b1, 1'b0, 32'd0,     1'b0, 1'b1, 32'h208};
    vecs[17] = '{3'd2, 32'h208, 32'h300, 1'b0, 12'h342, 1'b1, 1'b0, 32'd0,     1'b0, 1'b1, 32'd1};

    rstn = 1'b0; trap_type = 3'd0; mepc_in = '0; mtvec_addr = '0; mret = 1'b0; csr_raddr = 12'h342;
    #1;
    chk_all_zero("reset");
    chk("reset.csr_rdata", csr_rdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      trap_type  = vecs[i].tt;
      mepc_in    = vecs[i].mepc;
      mtvec_addr = vecs[i].mtvec;
      mret       = vecs[i].mret;
      csr_raddr  = vecs[i].raddr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.flush", i),       32'(flush),       32'(vecs[i].e_flush));
      chk($sformatf("v%0d.pc_redirect", i), 32'(pc_redirect), 32'(vecs[i].e_redir));
      chk($sformatf("v%0d.redirect_pc", i), redirect_pc,      vecs[i].e_rpc);
      chk($sformatf("v%0d.in_handler", i),  32'(in_handler),  32'(vecs[i].e_inh));
      chk($sformatf("v%0d.halted", i),      32'(halted),      32'(vecs[i].e_halt));
      chk($sformatf("v%0d.csr_rdata", i),   csr_rdata,        vecs[i].e_rdata);
    end

    // Async reset out of HALT takes effect without a clock edge
    @(negedge clk);
    trap_type = 3'd0; mret = 1'b0; csr_raddr = 12'h7C0;
    rstn = 1'b0;
    #1;
    chk_all_zero("halt_rst");
    chk("halt_rst.trap_cnt", csr_rdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Level held for 10 cycles counts as a single trap
    for (int c = 0; c < 10; c++) step(3'd3, 1'b0);
    step(3'd0, 1'b0);
    chk("held.in_handler", 32'(in_handler), 32'd1);
    chk("held.trap_cnt", csr_rdata, 32'd1);
    csr_raddr = 12'h342;
    #1;
    chk("held.mcause", csr_rdata, 32'd3);
    step(3'd0, 1'b1);
    step(3'd0, 1'b0);
    chk_all_zero("held_ret");

    // Async reset while flushing drops flush mid-cycle
    step(3'd2, 1'b0);
    chk("frst.flush_before", 32'(flush), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("frst.flush_after", 32'(flush), 32'd0);
    chk("frst.flush2_after", 32'(flush2), 32'd0);
    @(negedge clk);
    trap_type = 3'd0;
    rstn = 1'b1;

    // Five separate trap/mret sequences: narrow counter saturates at 3
    csr_raddr = 12'h7C0;
    for (int s = 0; s < 5; s++) begin
      step(3'd1, 1'b0);
      if (s == 0) chk("fc3.c1_redirect", 32'(pc_redirect2), 32'd0);
      for (int c = 2; c <= 6; c++) begin
        step(3'd0, 1'b0);
        if (s == 0 && c <= 5)
          chk($sformatf("fc3.c%0d_redirect", c), 32'(pc_redirect2), 32'(c == 4));
      end
      if (s == 0) chk("fc3.c6_in_handler", 32'(in_handler2), 32'd1);
      step(3'd0, 1'b1);
      step(3'd0, 1'b0);
      step(3'd0, 1'b0);
    end
    chk("sat.trap_cnt_w2", csr_rdata2, 32'd3);
    chk("sat.trap_cnt_w8", csr_rdata, 32'd5);
    chk("sat.in_handler", 32'(in_handler), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
